fifo_stream_reader: RTL and testbench

//  Read-side engine for the 32-deep x 32b sync FIFO: pops bursts of words from it and

---
 rtl/fifo_stream_reader_if.sv | 23 ++
 rtl/fifo_stream_reader.sv | 138 +++++++++++++
 tb/tb_fifo_stream_reader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready master stream used by fifo_stream_reader.
// master = the reader engine, slave = the FIFO/sink side that faces it.
interface fifo_stream_reader_if #(
    parameter int DW = 32
);
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    modport master (
        input  fifo_empty, fifo_dout, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_dout, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Burst read engine: pops words from a sync FIFO (1-cycle read latency) into a 2-entry
// output buffer that drives a valid/ready stream. Optional macro FIFO_RD_STATS_EN adds words_total.
module fifo_stream_reader #(
    parameter int DW   = 32,
    parameter int LENW = 8
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [LENW-1:0]      burst_len,
    output logic                 busy,
    output logic                 done,
`ifdef FIFO_RD_STATS_EN
    output logic [31:0]          words_total,
`endif
    fifo_stream_reader_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [LENW:0] ONE      = {{LENW{1'b0}}, 1'b1};
    localparam logic [LENW:0] MAX_BURST = {1'b1, {LENW{1'b0}}};

    state_t        state;
    state_t        state_nxt;
    logic [LENW:0] len;
    logic [LENW:0] issue_cnt;
    logic [LENW:0] out_cnt;
    logic [1:0]    buf_cnt;
    logic          inflight;
    logic [DW-1:0] head_data;
    logic [DW-1:0] tail_data;
    logic          hs;
    logic          rd_en;

    assign hs           = bus.m_valid & bus.m_ready;
    assign bus.m_valid  = (buf_cnt != 2'd0);
    assign bus.m_data   = head_data;
    assign bus.m_last   = bus.m_valid & (out_cnt == (len - ONE));
    assign bus.fifo_rd_en = rd_en;

    always_ff @(posedge clk or negedge srst) begin
        if (!srst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Credits count words already in the buffer plus the one in flight, so a beat
    // handed off this cycle only frees its slot on the following cycle.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        rd_en     = (state == RUN) & ~bus.fifo_empty & (issue_cnt < len) &
                    (({1'b0, buf_cnt} + {2'b00, inflight}) < 3'd2);
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (issue_cnt == len) state_nxt = FLUSH;
            FLUSH:   if (hs && bus.m_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge srst) begin
        if (!srst) begin
            len       <= '0;
            issue_cnt <= '0;
            out_cnt   <= '0;
            buf_cnt   <= 2'd0;
            inflight  <= 1'b0;
            head_data <= '0;
            tail_data <= '0;
        end else if (abort) begin
            issue_cnt <= '0;
            out_cnt   <= '0;
            buf_cnt   <= 2'd0;
            inflight  <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (state == IDLE && start) begin
                len       <= (burst_len == '0) ? MAX_BURST : {1'b0, burst_len};
                issue_cnt <= '0;
                out_cnt   <= '0;
            end else begin
                if (rd_en) issue_cnt <= issue_cnt + ONE;
                if (hs)    out_cnt   <= out_cnt + ONE;
            end
            // Read data lands one cycle after the pop; capture and drain may coincide.
            case ({inflight, hs})
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        head_data <= bus.fifo_dout;
                        buf_cnt   <= 2'd1;
                    end else begin
                        tail_data <= bus.fifo_dout;
                        buf_cnt   <= 2'd2;
                    end
                end
                2'b01: begin
                    head_data <= tail_data;
                    buf_cnt   <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        head_data <= bus.fifo_dout;
                    end else begin
                        head_data <= tail_data;
                        tail_data <= bus.fifo_dout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FIFO_RD_STATS_EN
    always_ff @(posedge clk or negedge srst) begin
        if (!srst) begin
            words_total <= '0;
        end else if (hs) begin
            words_total <= words_total + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed + randomized bench for fifo_stream_reader; a queue-based model of popped/accepted
// words predicts every output each cycle. Define FIFO_RD_STATS_EN to also check words_total.
module tb_fifo_stream_reader;

    typedef struct {
        logic [31:0] data;
        int          vis;
    } ent_t;

    logic        clk;
    logic        srst;
    logic        start;
    logic        abort;
    logic [7:0]  burst_len;
    logic        busy;
    logic        done;
`ifdef FIFO_RD_STATS_EN
    logic [31:0] words_total;
`endif

    fifo_stream_reader_if #(.DW(32)) bus ();

    fifo_stream_reader #(.DW(32), .LENW(8)) dut (
        .clk        (clk),
        .srst       (srst),
        .start      (start),
        .abort      (abort),
        .burst_len  (burst_len),
        .busy       (busy),
        .done       (done),
`ifdef FIFO_RD_STATS_EN
        .words_total(words_total),
`endif
        .bus        (bus)
    );

    int          checks;
    int          errors;
    int          cyc;
    logic [31:0] fifo_q[$];
    ent_t        q[$];
    logic        busy_m;
    logic        done_m;
    int          len_m;
    int          popped;
    int          accepted;
    logic [31:0] total_m;
    int          rd_seen;
    int          beats_seen;
    logic [31:0] last_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: called just after a rising edge with inputs already set.
    task automatic cycle();
        logic        exp_valid, exp_rd, exp_last, hs, is_last;
        logic [31:0] w;
        bus.fifo_empty = (fifo_q.size() == 0);
        @(negedge clk);
        exp_valid = (q.size() > 0) && (q[0].vis <= cyc);
        exp_rd    = busy_m && (fifo_q.size() != 0) && (popped < len_m) && (q.size() < 2);
        exp_last  = exp_valid && (accepted == len_m - 1);
        chk("busy", 32'(busy), 32'(busy_m));
        chk("done", 32'(done), 32'(done_m));
        chk("fifo_rd_en", 32'(bus.fifo_rd_en), 32'(exp_rd));
        chk("m_valid", 32'(bus.m_valid), 32'(exp_valid));
        chk("m_last", 32'(bus.m_last), 32'(exp_last));
        if (exp_valid) chk("m_data", bus.m_data, q[0].data);
`ifdef FIFO_RD_STATS_EN
        chk("words_total", words_total, total_m);
`endif
        if (bus.fifo_rd_en) rd_seen++;
        if (bus.m_valid && bus.m_ready) begin
            beats_seen++;
            if (bus.m_last) last_data = bus.m_data;
        end
        hs      = exp_valid && bus.m_ready;
        is_last = hs && exp_last;
        @(posedge clk);
        #1;
        w = $urandom();
        if (exp_rd) begin
            w = fifo_q.pop_front();
            bus.fifo_dout = w;
        end else begin
            bus.fifo_dout = $urandom();
        end
        if (abort) begin
            busy_m = 1'b0; done_m = 1'b0; q.delete(); popped = 0; accepted = 0;
        end else begin
            if (hs) begin
                q.pop_front();
                accepted++;
            end
            if (exp_rd) begin
                q.push_back(ent_t'{data: w, vis: cyc + 2});
                popped++;
            end
            if (done_m) begin
                done_m = 1'b0; busy_m = 1'b0;
            end else if (is_last) begin
                done_m = 1'b1;
            end else if (!busy_m && start) begin
                busy_m = 1'b1; popped = 0; accepted = 0;
                len_m = (burst_len == 8'd0) ? 256 : int'(burst_len);
            end
        end
        if (hs) total_m = total_m + 32'd1;
        cyc++;
        start = 1'b0;
        abort = 1'b0;
    endtask

    // ready_mode: 0 always ready, 1 toggling, 2 random. abort_at < 0 disables abort.
    task automatic applyStimulus(input int len, input int budget, input int ready_mode,
                                 input int feed_n, input int feed_gap,
                                 input logic [31:0] feed_base, input int abort_at);
        int   n, fed;
        logic aborted;
        fed = 0; n = 0; aborted = 1'b0;
        start = 1'b1;
        burst_len = 8'(len);
        m_ready_set(1'b1);
        cycle();
        while (busy_m && n < budget) begin
            if (fed < feed_n && (n % feed_gap) == 0) begin
                fifo_q.push_back(feed_base + 32'(fed));
                fed++;
            end
            case (ready_mode)
                0:       m_ready_set(1'b1);
                1:       m_ready_set(n[0] == 1'b0);
                default: m_ready_set($urandom_range(0, 1) == 1);
            endcase
            if (!aborted && abort_at >= 0 && accepted == abort_at) begin
                abort = 1'b1;
                aborted = 1'b1;
            end
            cycle();
            n++;
        end
        chk("burst_finished_busy", 32'(busy), 32'd0);
    endtask

    task automatic m_ready_set(input logic v);
        bus.m_ready = v;
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_rd_en"}, 32'(bus.fifo_rd_en), 32'd0);
        chk({tag, "_m_valid"}, 32'(bus.m_valid), 32'd0);
        chk({tag, "_m_last"}, 32'(bus.m_last), 32'd0);
        chk({tag, "_m_data"}, bus.m_data, 32'd0);
`ifdef FIFO_RD_STATS_EN
        chk({tag, "_words_total"}, words_total, 32'd0);
`endif
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        busy_m = 1'b0; done_m = 1'b0; len_m = 0; popped = 0; accepted = 0; total_m = '0;
        rd_seen = 0; beats_seen = 0; last_data = '0;
        srst = 1'b0; start = 1'b0; abort = 1'b0; burst_len = 8'd0;
        bus.fifo_empty = 1'b1; bus.fifo_dout = '0; bus.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        srst = 1'b1;

        $display("[TB] 4-word burst, sink always ready");
        for (int i = 0; i < 4; i++) fifo_q.push_back(32'hA0 + 32'(i));
        rd_seen = 0; beats_seen = 0;
        applyStimulus(4, 40, 0, 0, 1, 32'd0, -1);
        chk("t1_rd_pulses", 32'(rd_seen), 32'd4);
        chk("t1_beats", 32'(beats_seen), 32'd4);
        chk("t1_last_data", last_data, 32'hA3);

        $display("[TB] 4-word burst, sink toggling");
        for (int i = 0; i < 4; i++) fifo_q.push_back($urandom());
        beats_seen = 0;
        applyStimulus(4, 60, 1, 0, 1, 32'd0, -1);
        chk("t2_beats", 32'(beats_seen), 32'd4);

        $display("[TB] 256-word burst, writer at 1/3 rate");
        rd_seen = 0; beats_seen = 0;
        applyStimulus(0, 900, 2, 256, 3, 32'd0, -1);
        chk("t3_rd_pulses", 32'(rd_seen), 32'd256);
        chk("t3_beats", 32'(beats_seen), 32'd256);
        chk("t3_last_data", last_data, 32'd255);

        $display("[TB] abort after 2 of 8 beats, then clean burst");
        for (int i = 0; i < 8; i++) fifo_q.push_back(32'h100 + 32'(i));
        applyStimulus(8, 60, 0, 0, 1, 32'd0, 2);
        applyStimulus(3, 60, 0, 3, 1, 32'h200, -1);

        $display("[TB] start while busy is ignored");
        for (int i = 0; i < 5; i++) fifo_q.push_back(32'h300 + 32'(i));
        start = 1'b1; burst_len = 8'd5; bus.m_ready = 1'b1;
        cycle();
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; burst_len = 8'd2;
            cycle();
        end
        for (int i = 0; i < 30 && busy_m; i++) cycle();
        chk("t5_idle", 32'(busy), 32'd0);

        $display("[TB] async reset mid-burst");
        for (int i = 0; i < 10; i++) fifo_q.push_back($urandom());
        start = 1'b1; burst_len = 8'd10;
        cycle();
        for (int i = 0; i < 5; i++) cycle();
        srst = 1'b0;
        #1;
        checkOutput("async_reset");
        busy_m = 1'b0; done_m = 1'b0; q.delete(); popped = 0; accepted = 0; total_m = '0;
        fifo_q.delete();
        @(posedge clk);
        #1;
        srst = 1'b1;

        $display("[TB] bursts of 3 and 5 around an aborted burst");
        applyStimulus(3, 40, 2, 3, 1, 32'h400, -1);
        applyStimulus(6, 60, 0, 6, 1, 32'h500, 1);
        fifo_q.delete();
        applyStimulus(5, 60, 2, 5, 2, 32'h600, -1);

        $display("[TB] random bursts");
        for (int b = 0; b < 6; b++) begin
            int l;
            l = $urandom_range(1, 20);
            applyStimulus(l, 200, 2, l, $urandom_range(1, 3), $urandom(), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
